mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage access unit that turns EX/MEM load/store requests into a
//   registered request on a simple data-memory bus.
//   It holds the pipeline while an access is in flight.
//   It formats byte and word load data.
//   It aborts an access if the bus never answers within TIMEOUT_CYCLES.
//
// Parameters
//   TIMEOUT_CYCLES  max BUSY cycles spent waiting for dmem_ready (1..255)
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   Memread_in        load request
//   Memwrite_in       store request (wins over a simultaneous load)
//   Byte_in           1 = byte access, 0 = word access
//   Signext2_in       1 = sign-extend byte load
//   ALU_result_in     effective byte address
//   B_in              store data
//   dmem_req/we/addr/wdata/be   registered bus request
//   dmem_ready, dmem_rdata      bus completion and read data
//   mem_stall         combinational EX/MEM hold
//   Load_data_out     formatted load result, held until the next completion
//   Load_valid_out    one-cycle pulse when a load completes
//   addr_err_out      combinational misaligned-word flag (IDLE only)
//   bus_err_out       one-cycle pulse when an access times out
//   state_dbg         current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a request is accepted in IDLE when it is aligned.
// dmem_req then stays high with stable attributes until a rising edge samples dmem_ready=1.
// The access is also dropped if the timeout expires first.
// One DONE cycle always follows, so accesses are spaced at least 3 cycles apart.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Memread_in,
    input  logic        Memwrite_in,
    input  logic        Byte_in,
    input  logic        Signext2_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] B_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] Load_data_out,
    output logic        Load_valid_out,
    output logic        addr_err_out,
    output logic        bus_err_out,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        lat_we;
    logic        lat_byte;
    logic        lat_sx;
    logic [1:0]  lat_lo;

    logic        req_any;
    logic        misaligned;
    logic [7:0]  sel_byte;
    logic [31:0] load_fmt;

    assign req_any    = Memread_in | Memwrite_in;
    assign misaligned = !Byte_in && (ALU_result_in[1:0] != 2'b00);

    // A misaligned request is rejected without stalling.
    // The pipeline then moves on and can report the fault.
    assign addr_err_out = (state == IDLE) && req_any && misaligned;
    assign mem_stall    = (state == BUSY) ||
                          ((state == IDLE) && req_any && !misaligned);
    assign state_dbg    = state;

    // Little-endian lane select from the latched address bits.
    always_comb begin
        sel_byte = 8'h00;
        case (lat_lo)
            2'd0:    sel_byte = dmem_rdata[7:0];
            2'd1:    sel_byte = dmem_rdata[15:8];
            2'd2:    sel_byte = dmem_rdata[23:16];
            default: sel_byte = dmem_rdata[31:24];
        endcase
    end

    assign load_fmt = lat_byte ? {{24{lat_sx & sel_byte[7]}}, sel_byte}
                               : dmem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            lat_we         <= 1'b0;
            lat_byte       <= 1'b0;
            lat_sx         <= 1'b0;
            lat_lo         <= 2'b00;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_wdata     <= 32'd0;
            dmem_be        <= 4'd0;
            Load_data_out  <= 32'd0;
            Load_valid_out <= 1'b0;
            bus_err_out    <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses; they are asserted
            // only on the edge that enters DONE.
            Load_valid_out <= 1'b0;
            bus_err_out    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any && !misaligned) begin
                        state     <= BUSY;
                        cnt       <= 8'd0;
                        dmem_req  <= 1'b1;
                        dmem_we   <= Memwrite_in;
                        dmem_addr <= {ALU_result_in[31:2], 2'b00};
                        lat_we    <= Memwrite_in;
                        lat_byte  <= Byte_in;
                        lat_sx    <= Signext2_in;
                        lat_lo    <= ALU_result_in[1:0];
                        if (Memwrite_in && Byte_in) begin
                            dmem_be    <= 4'b0001 << ALU_result_in[1:0];
                            dmem_wdata <= {4{B_in[7:0]}};
                        end else if (Memwrite_in) begin
                            dmem_be    <= 4'hF;
                            dmem_wdata <= B_in;
                        end else begin
                            dmem_be    <= 4'hF;
                            dmem_wdata <= 32'd0;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        state          <= DONE;
                        dmem_req       <= 1'b0;
                        dmem_we        <= 1'b0;
                        Load_data_out  <= lat_we ? 32'd0 : load_fmt;
                        Load_valid_out <= !lat_we;
                    end else if (cnt == TO_LAST) begin
                        state         <= DONE;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        Load_data_out <= 32'd0;
                        bus_err_out   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // Inputs seen in DONE belong to an instruction that has
                    // not yet advanced, so they must not start an access.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit with hand-computed expected values.
//   Inputs are driven 1 time unit after each rising edge.
//   Outputs are checked before the next edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Memread_in, Memwrite_in, Byte_in, Signext2_in;
    logic [31:0] ALU_result_in, B_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] Load_data_out;
    logic        Load_valid_out, addr_err_out, bus_err_out;
    logic [1:0]  state_dbg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cycles = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .Memread_in(Memread_in), .Memwrite_in(Memwrite_in),
        .Byte_in(Byte_in), .Signext2_in(Signext2_in),
        .ALU_result_in(ALU_result_in), .B_in(B_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .Load_data_out(Load_data_out),
        .Load_valid_out(Load_valid_out), .addr_err_out(addr_err_out),
        .bus_err_out(bus_err_out), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(negedge clk) if (mem_stall) stall_cycles++;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Memread_in = 0; Memwrite_in = 0; Byte_in = 0; Signext2_in = 0;
        ALU_result_in = 0; B_in = 0;
    endtask

    // One complete access with the bus answering on BUSY cycle 'lat'.
    // The request inputs are scrambled during BUSY.
    // The result must come from the attributes latched at BUSY entry.
    task automatic run_access(input logic rd, input logic wr, input logic byt,
                              input logic sx, input logic [31:0] addr,
                              input logic [31:0] bdata, input logic [31:0] rdata,
                              input int lat, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_load);
        logic        exp_lv;
        logic [31:0] exp_ld;
        exp_lv = rd & !wr;
        exp_ld = exp_lv ? exp_load : 32'd0;
        if (exp_lv) exp_q.push_back(exp_load);
        Memread_in = rd; Memwrite_in = wr; Byte_in = byt; Signext2_in = sx;
        ALU_result_in = addr; B_in = bdata;
        stall_cycles = 0;
        #1;
        check_eq("idle_stall", 32'(mem_stall), 32'd1);
        check_eq("idle_addr_err", 32'(addr_err_out), 32'd0);
        step();
        check_eq("busy_state", 32'(state_dbg), 32'(S_BUSY));
        check_eq("req", 32'(dmem_req), 32'd1);
        check_eq("we", 32'(dmem_we), 32'(wr));
        check_eq("addr", dmem_addr, exp_addr);
        check_eq("be", 32'(dmem_be), 32'(exp_be));
        check_eq("wdata", dmem_wdata, exp_wdata);
        ALU_result_in = ~addr; Byte_in = ~byt; Signext2_in = ~sx; B_in = ~bdata;
        for (int i = 1; i < lat; i++) begin
            step();
            check_eq("busy_req_hold", 32'(dmem_req), 32'd1);
            check_eq("busy_addr_hold", dmem_addr, exp_addr);
            check_eq("busy_wdata_hold", dmem_wdata, exp_wdata);
        end
        dmem_ready = 1; dmem_rdata = rdata;
        step();
        dmem_ready = 0; dmem_rdata = 32'h5555AAAA;
        check_eq("done_state", 32'(state_dbg), 32'(S_DONE));
        check_eq("done_valid", 32'(Load_valid_out), 32'(exp_lv));
        check_eq("done_req", 32'(dmem_req), 32'd0);
        check_eq("done_we", 32'(dmem_we), 32'd0);
        check_eq("done_stall", 32'(mem_stall), 32'd0);
        check_eq("done_bus_err", 32'(bus_err_out), 32'd0);
        check_eq("done_load_data", Load_data_out, exp_ld);
        if (Load_valid_out) begin
            if (exp_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
            else check_eq("sb_load_data", Load_data_out, exp_q.pop_front());
        end
        step();
        check_eq("post_state", 32'(state_dbg), 32'(S_IDLE));
        check_eq("post_req", 32'(dmem_req), 32'd0);
        check_eq("post_valid", 32'(Load_valid_out), 32'd0);
        check_eq("post_hold", Load_data_out, exp_ld);
        check_eq("stall_cycles", 32'(stall_cycles), 32'(lat + 1));
        clear_inputs();
    endtask

    initial begin
        rst = 0; dmem_ready = 0; dmem_rdata = 0;
        clear_inputs();
        #2;
        check_eq("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_we", 32'(dmem_we), 32'd0);
        check_eq("rst_addr", dmem_addr, 32'd0);
        check_eq("rst_wdata", dmem_wdata, 32'd0);
        check_eq("rst_be", 32'(dmem_be), 32'd0);
        check_eq("rst_load_data", Load_data_out, 32'd0);
        check_eq("rst_valid", 32'(Load_valid_out), 32'd0);
        check_eq("rst_bus_err", 32'(bus_err_out), 32'd0);
        step();
        rst = 1;
        step();

        //          rd wr by sx addr          bdata         rdata         lat addr          be       wdata         load
        run_access(1, 0, 0, 0, 32'h00000100, 32'h0,        32'hDEADBEEF, 2, 32'h00000100, 4'hF,    32'h0,        32'hDEADBEEF);
        run_access(1, 0, 1, 1, 32'h00000103, 32'h0,        32'h80FF0000, 1, 32'h00000100, 4'hF,    32'h0,        32'hFFFFFF80);
        run_access(1, 0, 1, 0, 32'h00000103, 32'h0,        32'h80FF0000, 2, 32'h00000100, 4'hF,    32'h0,        32'h00000080);
        run_access(0, 1, 1, 0, 32'h00000202, 32'h123456AB, 32'h0,        1, 32'h00000200, 4'b0100, 32'hABABABAB, 32'h0);
        run_access(1, 0, 1, 1, 32'h00000101, 32'h0,        32'h12347F56, 1, 32'h00000100, 4'hF,    32'h0,        32'h0000007F);
        run_access(0, 1, 0, 0, 32'h00000300, 32'hCAFEF00D, 32'h0,        3, 32'h00000300, 4'hF,    32'hCAFEF00D, 32'h0);
        run_access(1, 1, 1, 0, 32'h00000001, 32'h0000005A, 32'hFFFFFFFF, 1, 32'h00000000, 4'b0010, 32'h5A5A5A5A, 32'h0);
        run_access(1, 0, 1, 0, 32'h00000102, 32'h0,        32'h00C30000, 2, 32'h00000100, 4'hF,    32'h0,        32'h000000C3);

        // Misaligned word load is rejected in place.
        Memread_in = 1; ALU_result_in = 32'h00000105;
        #1;
        check_eq("mis_addr_err", 32'(addr_err_out), 32'd1);
        check_eq("mis_stall", 32'(mem_stall), 32'd0);
        step();
        check_eq("mis_req", 32'(dmem_req), 32'd0);
        check_eq("mis_state", 32'(state_dbg), 32'(S_IDLE));
        Memread_in = 0; Memwrite_in = 1; ALU_result_in = 32'h00000302;
        #1;
        check_eq("mis_st_addr_err", 32'(addr_err_out), 32'd1);
        step();
        check_eq("mis_st_req", 32'(dmem_req), 32'd0);
        clear_inputs();
        #1;
        check_eq("noreq_addr_err", 32'(addr_err_out), 32'd0);

        // Timeout: TIMEOUT_CYCLES=4 and the bus never answers.
        Memread_in = 1; ALU_result_in = 32'h00000040;
        step();
        check_eq("to_req_1", 32'(dmem_req), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            check_eq("to_req_hold", 32'(dmem_req), 32'd1);
            check_eq("to_no_bus_err", 32'(bus_err_out), 32'd0);
        end
        step();
        check_eq("to_req_drop", 32'(dmem_req), 32'd0);
        check_eq("to_bus_err", 32'(bus_err_out), 32'd1);
        check_eq("to_load_data", Load_data_out, 32'd0);
        check_eq("to_valid", 32'(Load_valid_out), 32'd0);
        check_eq("to_state", 32'(state_dbg), 32'(S_DONE));
        clear_inputs();
        step();
        check_eq("to_bus_err_pulse", 32'(bus_err_out), 32'd0);
        check_eq("to_idle", 32'(state_dbg), 32'(S_IDLE));

        // Reset in the middle of BUSY abandons the access.
        Memread_in = 1; ALU_result_in = 32'h00000080;
        step();
        check_eq("rb_req", 32'(dmem_req), 32'd1);
        #2;
        rst = 0;
        clear_inputs();
        #1;
        check_eq("rb_req_async", 32'(dmem_req), 32'd0);
        check_eq("rb_state_async", 32'(state_dbg), 32'(S_IDLE));
        check_eq("rb_stall", 32'(mem_stall), 32'd0);
        step();
        rst = 1;
        dmem_ready = 1; dmem_rdata = 32'h11223344;
        step();
        dmem_ready = 0;
        check_eq("rb_no_valid", 32'(Load_valid_out), 32'd0);
        check_eq("rb_no_bus_err", 32'(bus_err_out), 32'd0);
        check_eq("rb_load_data", Load_data_out, 32'd0);
        step();
        check_eq("rb_no_valid_2", 32'(Load_valid_out), 32'd0);
        check_eq("rb_req_idle", 32'(dmem_req), 32'd0);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
